// File: rtl/alu_div_pkg.sv
// Shared definitions for the sequential ALU divider: FSM encodings and counter sizing.
package alu_div_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StDivide = 3'd2,
    StSign   = 3'd3,
    StDone   = 3'd4
  } state_e;

  // Width of the iteration counter, which counts down from WIDTH-1 to 0.
  function automatic int unsigned step_cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, select.
module div_restore_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_qm,
  input  logic [WIDTH-1:0] i_dm,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_qm
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  // Keep the trial difference when it is non-negative, otherwise restore.
  always_comb begin
    w_shift = {i_rem[WIDTH-1:0], i_qm[WIDTH-1]};
    w_trial = w_shift - {1'b0, i_dm};
    if (!w_trial[WIDTH]) begin
      o_rem = w_trial;
      o_qm  = {i_qm[WIDTH-2:0], 1'b1};
    end else begin
      o_rem = w_shift;
      o_qm  = {i_qm[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: restoring division on magnitudes, sign fix at the end.
module seq_signed_divider
  import alu_div_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero,
  output logic             o_overflow
);

  localparam int unsigned CntW = step_cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  state_e r_state;
  state_e w_state_nxt;

  logic [WIDTH-1:0] r_dvd, r_dvs, r_qm, r_dm;
  logic [WIDTH:0]   r_rem;
  logic [CntW-1:0]  r_cnt;
  logic             r_sign_q, r_sign_r, r_dz;
  logic [WIDTH-1:0] r_quot, r_remd;
  logic             r_dbz, r_ovf;

  logic             w_accept;
  logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag, w_q_fix, w_r_fix;
  logic [WIDTH:0]   w_step_rem;
  logic [WIDTH-1:0] w_step_qm;

  assign w_accept = i_start && ((r_state == StIdle) || (r_state == StDone));

  // Magnitudes and final sign fix; |MIN| wraps to 2^(WIDTH-1), which is correct unsigned.
  assign w_dvd_mag = r_dvd[WIDTH-1] ? (~r_dvd + WIDTH'(1)) : r_dvd;
  assign w_dvs_mag = r_dvs[WIDTH-1] ? (~r_dvs + WIDTH'(1)) : r_dvs;
  assign w_q_fix   = r_sign_q ? (~r_qm + WIDTH'(1)) : r_qm;
  assign w_r_fix   = r_sign_r ? (~r_rem[WIDTH-1:0] + WIDTH'(1)) : r_rem[WIDTH-1:0];

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem(r_rem),
    .i_qm (r_qm),
    .i_dm (r_dm),
    .o_rem(w_step_rem),
    .o_qm (w_step_qm)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (i_start) w_state_nxt = StLoad;
      StLoad:   w_state_nxt = (r_dvs == '0) ? StSign : StDivide;
      StDivide: if (r_cnt == '0) w_state_nxt = StSign;
      StSign:   w_state_nxt = StDone;
      StDone:   w_state_nxt = i_start ? StLoad : StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_qm     <= '0;
      r_dm     <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_dz     <= 1'b0;
      r_quot   <= '0;
      r_remd   <= '0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dvd    <= i_dividend;
        r_dvs    <= i_divisor;
        r_sign_q <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
        r_sign_r <= i_dividend[WIDTH-1];
      end
      case (r_state)
        StLoad: begin
          r_qm  <= w_dvd_mag;
          r_dm  <= w_dvs_mag;
          r_rem <= '0;
          r_cnt <= CntW'(WIDTH - 1);
          r_dz  <= (r_dvs == '0);
        end
        StDivide: begin
          r_rem <= w_step_rem;
          r_qm  <= w_step_qm;
          r_cnt <= r_cnt - CntW'(1);
        end
        StSign: begin
          if (r_dz) begin
            r_quot <= '1;
            r_remd <= r_dvd;
            r_dbz  <= 1'b1;
            r_ovf  <= 1'b0;
          end else begin
            r_quot <= w_q_fix;
            r_remd <= w_r_fix;
            r_dbz  <= 1'b0;
            r_ovf  <= (r_dvd == MinVal) && (r_dvs == '1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state == StLoad) || (r_state == StDivide) || (r_state == StSign);
  assign o_done        = (r_state == StDone);
  assign o_quotient    = r_quot;
  assign o_remainder   = r_remd;
  assign o_div_by_zero = r_dbz;
  assign o_overflow    = r_ovf;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider with directed, hand-computed vectors.
module tb_seq_signed_divider;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_dividend = '0;
  logic [15:0] i_divisor = '0;
  logic        o_busy, o_done, o_div_by_zero, o_overflow;
  logic [15:0] o_quotient, o_remainder;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  seq_signed_divider #(
    .WIDTH(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_dividend   (i_dividend),
    .i_divisor    (i_divisor),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_quotient   (o_quotient),
    .o_remainder  (o_remainder),
    .o_div_by_zero(o_div_by_zero),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one operation and record its expected result and done cycle.
  task automatic issue(input logic [15:0] dvd, input logic [15:0] dvs, input logic [15:0] q,
                       input logic [15:0] r, input logic dbz, input logic ovf, input int lat);
    exp_t e;
    @(negedge clk);
    i_start    = 1'b1;
    i_dividend = dvd;
    i_divisor  = dvs;
    @(posedge clk);
    #1;
    e.q   = q;
    e.r   = r;
    e.dbz = dbz;
    e.ovf = ovf;
    e.due = cyc + lat;
    exp_q.push_back(e);
    i_start    = 1'b0;
    i_dividend = 16'($urandom);
    i_divisor  = 16'($urandom);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (o_done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start(input logic [15:0] dvd, input logic [15:0] dvs);
    @(negedge clk);
    i_start    = 1'b1;
    i_dividend = dvd;
    i_divisor  = dvs;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Monitor: every done pulse pops the oldest expectation and compares.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (o_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("quotient", {16'd0, o_quotient}, {16'd0, e.q});
          chk("remainder", {16'd0, o_remainder}, {16'd0, e.r});
          chk("div_by_zero", {31'd0, o_div_by_zero}, {31'd0, e.dbz});
          chk("overflow", {31'd0, o_overflow}, {31'd0, e.ovf});
          chk("done_cycle", cyc, e.due);
          chk("busy_in_done", {31'd0, o_busy}, 32'd0);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_quot", {16'd0, o_quotient}, 32'd0);
    chk("rst_rem", {16'd0, o_remainder}, 32'd0);
    chk("rst_dbz", {31'd0, o_div_by_zero}, 32'd0);
    chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 18);
    @(posedge clk);
    #1;
    chk("busy_during", {31'd0, o_busy}, 32'd1);
    wait_done();
    repeat (2) @(negedge clk);

    issue(16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 18);
    wait_done();
    issue(16'd100, 16'hFFF9, 16'hFFF2, 16'd2, 1'b0, 1'b0, 18);
    wait_done();
    repeat (1) @(negedge clk);

    issue(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 1'b1, 18);
    wait_done();
    issue(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 1'b0, 18);
    wait_done();

    issue(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1'b0, 2);
    wait_done();
    repeat (2) @(negedge clk);

    // Starts while busy must be ignored; the start in the done cycle must be accepted.
    issue(16'd1234, 16'd10, 16'd123, 16'd4, 1'b0, 1'b0, 18);
    repeat (2) @(negedge clk);
    pulse_start(16'd7, 16'd3);
    repeat (5) @(negedge clk);
    pulse_start(16'hFFCE, 16'd5);
    wait_done();
    issue(16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 18);
    wait_done();
    repeat (2) @(negedge clk);

    // Reset in flight: outputs clear at once and the aborted op never completes.
    @(negedge clk);
    i_start    = 1'b1;
    i_dividend = 16'd1000;
    i_divisor  = 16'd3;
    @(negedge clk);
    i_start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("mid_rst_done", {31'd0, o_done}, 32'd0);
    chk("mid_rst_quot", {16'd0, o_quotient}, 32'd0);
    chk("mid_rst_rem", {16'd0, o_remainder}, 32'd0);
    chk("mid_rst_dbz", {31'd0, o_div_by_zero}, 32'd0);
    chk("mid_rst_ovf", {31'd0, o_overflow}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);

    issue(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 1'b0, 18);
    wait_done();

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
